fc_argmax_sink: RTL

Downstream stage of the FC layer. Consumes the FC result stream (signed int8 class scores, four per 32-bit AXIS beat) and reduces it to the index and value of the largest score. It provides a completion flag and a length-check error for the APB control block. The block only accepts data after a start pulse and holds its results until the next start.

---
 rtl/fc_pkg.sv | 17 +
 rtl/fc_lane_max4.sv | 31 +++
 rtl/fc_argmax_sink.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the FC result-stream blocks.
// Covers lane geometry, the argmax FSM state encoding and the score floor.
package fc_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    localparam logic signed [LANE_W-1:0] SCORE_MIN = -8'sd128;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StFlush,
        StDone
    } fc_argmax_state_t;

endpackage

// File: rtl/fc_lane_max4.sv
// Combinational masked signed max over four int8 lanes.
// The lowest lane wins on a tie.
module fc_lane_max4
    import fc_pkg::*;
(
    input  logic [LANES*LANE_W-1:0] data,
    input  logic [LANES-1:0]        mask,
    output logic                    valid,
    output logic [1:0]              lane,
    output logic signed [LANE_W-1:0] value
);

    logic signed [LANE_W-1:0] v;

    always_comb begin
        valid = 1'b0;
        lane  = 2'd0;
        value = SCORE_MIN;
        v     = SCORE_MIN;
        for (int k = 0; k < int'(LANES); k++) begin
            v = $signed(data[k*LANE_W +: LANE_W]);
            // First masked lane is always taken so an all -128 beat still reports a lane.
            if (mask[k] && (!valid || v > value)) begin
                valid = 1'b1;
                lane  = 2'(k);
                value = v;
            end
        end
    end

endmodule

// File: rtl/fc_argmax_sink.sv
// Argmax reduction of the FC score stream with a two-stage merge pipeline.
// Results, done and err_len are held until the next accepted start.
module fc_argmax_sink
    import fc_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int IDX_W                = 11
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [IDX_W-1:0]                  num_elems,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              done,
    output logic [31:0]                       max_index,
    output logic signed [7:0]                 max_value,
    output logic [IDX_W-1:0]                  elem_count,
    output logic                              err_len
);

    localparam int PW = IDX_W + 2;

    fc_argmax_state_t state_q, state_d;

    logic [IDX_W-1:0]         num_q, pos_q;
    logic                     s1_valid_q, s1_lv_q, s1_last_q;
    logic signed [LANE_W-1:0] s1_max_q;
    logic [IDX_W-1:0]         s1_idx_q;
    logic [2:0]               s1_cnt_q;
    logic signed [LANE_W-1:0] run_max_q;
    logic [IDX_W-1:0]         run_idx_q, run_cnt_q;
    logic [1:0]               last_pipe_q;

    logic                     fire, arm, finish;
    logic [LANES-1:0]         lane_mask;
    logic [PW-1:0]            lane_pos [LANES];
    logic [2:0]               rank, cnt_d;
    logic                     lm_valid;
    logic [1:0]               lm_lane;
    logic signed [LANE_W-1:0] lm_value;

    assign S_AXIS_TREADY = (state_q == StRecv);
    assign fire          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign arm           = start && (state_q == StIdle || state_q == StDone);
    assign finish        = (state_q == StFlush) && (state_d == StDone);

    // Absolute position of each lane = running position + rank among kept lanes.
    always_comb begin
        rank      = 3'd0;
        cnt_d     = 3'd0;
        lane_mask = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_pos[k] = {2'b00, pos_q} + PW'(rank);
            if (S_AXIS_TKEEP[k]) begin
                rank = rank + 3'd1;
                if (lane_pos[k] < {2'b00, num_q}) begin
                    lane_mask[k] = 1'b1;
                    cnt_d        = cnt_d + 3'd1;
                end
            end
        end
    end

    fc_lane_max4 u_lane_max4 (
        .data  (S_AXIS_TDATA),
        .mask  (lane_mask),
        .valid (lm_valid),
        .lane  (lm_lane),
        .value (lm_value)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StRecv;
            StRecv:         if (fire && S_AXIS_TLAST) state_d = StFlush;
            // Hold FLUSH until the TLAST beat has cleared both pipeline stages.
            StFlush:        if (last_pipe_q[1]) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            last_pipe_q <= 2'b00;
            s1_valid_q  <= 1'b0;
            s1_lv_q     <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_max_q    <= SCORE_MIN;
            s1_idx_q    <= '0;
            s1_cnt_q    <= 3'd0;
            num_q       <= '0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= fire;
            last_pipe_q <= {last_pipe_q[0], s1_valid_q && s1_last_q};
            if (fire) begin
                s1_lv_q   <= lm_valid;
                s1_last_q <= S_AXIS_TLAST;
                s1_max_q  <= lm_value;
                s1_idx_q  <= lane_pos[lm_lane][IDX_W-1:0];
                s1_cnt_q  <= cnt_d;
                pos_q     <= pos_q + IDX_W'(cnt_d);
            end
            if (arm) begin
                num_q <= num_elems;
                pos_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_max_q  <= SCORE_MIN;
            run_idx_q  <= '0;
            run_cnt_q  <= '0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            max_index  <= '0;
            max_value  <= '0;
            elem_count <= '0;
        end else begin
            if (s1_valid_q) begin
                run_cnt_q <= run_cnt_q + IDX_W'(s1_cnt_q);
                if (s1_lv_q && s1_max_q > run_max_q) begin
                    run_max_q <= s1_max_q;
                    run_idx_q <= s1_idx_q;
                end
            end
            if (finish) begin
                max_index  <= 32'(run_idx_q);
                max_value  <= run_max_q;
                elem_count <= run_cnt_q;
                err_len    <= (run_cnt_q != num_q);
                done       <= 1'b1;
            end
            if (arm) begin
                run_max_q  <= SCORE_MIN;
                run_idx_q  <= '0;
                run_cnt_q  <= '0;
                elem_count <= '0;
                done       <= 1'b0;
                err_len    <= 1'b0;
            end
        end
    end

endmodule
